// File: rtl/float_stim_sequencer.sv
// Run controller for pipelined float operator benches: primes the generator, issues operands, tracks retirement.
// Optional FLOAT_STIM_SEQ_GAP_EN adds iv_Gap, a programmable bubble count after every issue.
module float_stim_sequencer #(
  parameter int pExpW     = 8,
  parameter int pManW     = 23,
  parameter int pPipeline = 5,
  parameter int pCntW     = 16
) (
  input  logic             i_Clk,
  input  logic             i_ARst_L,
  input  logic             i_Start,
  input  logic [pCntW-1:0] iv_Count,
  input  logic             i_Abort,
  input  logic             i_Hold,
`ifdef FLOAT_STIM_SEQ_GAP_EN
  input  logic [3:0]       iv_Gap,
`endif
  output logic             o_GenClkEn,
  output logic             o_OpValid,
  output logic             o_DutClkEn,
  output logic             o_ResValid,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [pCntW-1:0] ov_Issued,
  output logic [pCntW-1:0] ov_Retired
);

  if (pPipeline < 1 || pExpW < 1 || pManW < 1) begin : g_param_chk
    $error("float_stim_sequencer: pPipeline, pExpW and pManW must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [pCntW-1:0]       rem_q, rem_d;
  logic [pCntW-1:0]       issued_q, issued_d;
  logic [pCntW-1:0]       retired_q, retired_d;
  logic [pPipeline-1:0]   vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   issue_s;
  logic                   accept_s;
  logic                   gap_busy_s;

  assign accept_s = (state_q == ST_IDLE) & i_Start;
  assign issue_s  = (state_q == ST_RUN) & ~i_Hold & ~i_Abort & (rem_q != '0) & ~gap_busy_s;

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) state_d = (iv_Count != '0) ? ST_PRIME : ST_DONE;
        else         state_d = ST_IDLE;
      end
      ST_PRIME: begin
        if (i_Abort)      state_d = ST_DRAIN;
        else if (!i_Hold) state_d = ST_RUN;
        else              state_d = ST_PRIME;
      end
      ST_RUN: begin
        if (i_Abort)                              state_d = ST_DRAIN;
        else if (issue_s && rem_q == pCntW'(1))   state_d = ST_DRAIN;
        else                                      state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (vld_q == '0) state_d = ST_DONE;
        else             state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PRIME clocks the generator without flagging a real operand: its power-up contents are garbage.
  always_comb begin
    o_GenClkEn = 1'b0;
    o_OpValid  = 1'b0;
    o_DutClkEn = 1'b0;
    case (state_q)
      ST_PRIME: begin
        o_GenClkEn = ~i_Hold;
        o_DutClkEn = ~i_Hold;
      end
      ST_RUN: begin
        o_GenClkEn = issue_s;
        o_OpValid  = issue_s;
        o_DutClkEn = ~i_Hold;
      end
      ST_DRAIN: o_DutClkEn = ~i_Hold;
      default: begin
        o_GenClkEn = 1'b0;
        o_OpValid  = 1'b0;
        o_DutClkEn = 1'b0;
      end
    endcase
  end

  assign o_ResValid = vld_q[pPipeline-1] & ~i_Hold;

  always_comb begin
    rem_d     = rem_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    vld_d     = vld_q;
    if (accept_s) begin
      rem_d     = iv_Count;
      issued_d  = '0;
      retired_d = '0;
    end else begin
      if (issue_s) begin
        rem_d    = rem_q - pCntW'(1);
        issued_d = issued_q + pCntW'(1);
      end else begin
        rem_d    = rem_q;
        issued_d = issued_q;
      end
      if (o_ResValid) retired_d = retired_q + pCntW'(1);
      else            retired_d = retired_q;
    end
    if (!i_Hold) vld_d = pPipeline'({vld_q, o_OpValid});
    else         vld_d = vld_q;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      rem_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      vld_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef FLOAT_STIM_SEQ_GAP_EN
  logic [3:0] gap_q, gap_d;

  // Gap reloads on every issue and is flushed whenever the run heads into DRAIN.
  always_comb begin
    if (state_d == ST_DRAIN && state_q != ST_DRAIN) gap_d = 4'd0;
    else if (issue_s)                               gap_d = iv_Gap;
    else if (!i_Hold && gap_q != 4'd0)              gap_d = gap_q - 4'd1;
    else                                            gap_d = gap_q;
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) gap_q <= 4'd0;
    else           gap_q <= gap_d;
  end

  assign gap_busy_s = (gap_q != 4'd0);
`else
  assign gap_busy_s = 1'b0;
`endif

  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign ov_Issued  = issued_q;
  assign ov_Retired = retired_q;

endmodule

// File: tb/tb_float_stim_sequencer.sv
// Randomized bench for float_stim_sequencer against a queue-based model of issue/retire timing.
module tb_float_stim_sequencer;
  localparam int P = 5;
  localparam int W = 16;
`ifdef FLOAT_STIM_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_DRAIN = 3, M_DONE = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_hold = 1'b0;
  logic [W-1:0] iv_count = '0;
  logic [3:0] iv_gap = 4'd0;
  logic o_gen, o_opv, o_dut, o_res, o_busy, o_done;
  logic [W-1:0] ov_iss, ov_ret;

  float_stim_sequencer #(.pExpW(8), .pManW(23), .pPipeline(P), .pCntW(W)) dut (
    .i_Clk(clk), .i_ARst_L(rst_n), .i_Start(i_start), .iv_Count(iv_count),
    .i_Abort(i_abort), .i_Hold(i_hold),
`ifdef FLOAT_STIM_SEQ_GAP_EN
    .iv_Gap(iv_gap),
`endif
    .o_GenClkEn(o_gen), .o_OpValid(o_opv), .o_DutClkEn(o_dut), .o_ResValid(o_res),
    .o_Busy(o_busy), .o_Done(o_done), .ov_Issued(ov_iss), .ov_Retired(ov_ret));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  // model: phase, operands left, counters, gap, and per-operand cycles-to-retire
  int ms = M_IDLE, m_rem = 0, m_iss = 0, m_ret = 0, m_gap = 0;
  int q[$];
  bit obs_res, obs_done, obs_gen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = M_IDLE; m_rem = 0; m_iss = 0; m_ret = 0; m_gap = 0; q.delete();
  endtask

  task automatic step(input bit st, input bit ab, input bit hd, input int cnt, input int gp);
    bit e_issue, e_res;
    @(negedge clk);
    check_val("busy", o_busy, ms != M_IDLE);
    check_val("done", o_done, ms == M_DONE);
    check_val("issued", ov_iss, m_iss);
    check_val("retired", ov_ret, m_ret);
    i_start = st; i_abort = ab; i_hold = hd; iv_count = W'(cnt); iv_gap = 4'(gp);
    #1;
    e_issue = (ms == M_RUN) && !hd && !ab && m_rem != 0 && m_gap == 0;
    e_res   = !hd && q.size() > 0 && q[0] == 0;
    check_val("gen_clk_en", o_gen, (ms == M_PRIME) ? !hd : e_issue);
    check_val("op_valid", o_opv, e_issue);
    check_val("res_valid", o_res, e_res);
    check_val("dut_clk_en", o_dut, (ms == M_PRIME || ms == M_RUN || ms == M_DRAIN) && !hd);
    obs_res = o_res; obs_done = o_done; obs_gen = o_gen;
    if (e_res) m_ret++;
    case (ms)
      M_IDLE: if (st) begin
        m_iss = 0; m_ret = 0; m_gap = 0;
        if (cnt != 0) begin ms = M_PRIME; m_rem = cnt; end
        else ms = M_DONE;
      end
      M_PRIME: if (ab) ms = M_DRAIN; else if (!hd) ms = M_RUN;
      M_RUN: begin
        if (ab) begin ms = M_DRAIN; m_gap = 0; end
        else if (e_issue) begin
          m_rem--; m_iss++; m_gap = gp;
          if (m_rem == 0) begin ms = M_DRAIN; m_gap = 0; end
        end else if (!hd && m_gap > 0) m_gap--;
      end
      M_DRAIN: if (q.size() == 0) ms = M_DONE;
      default: ms = M_IDLE;
    endcase
    if (!hd) begin
      if (e_res) void'(q.pop_front());
      foreach (q[i]) q[i] = q[i] - 1;
      if (e_issue) q.push_back(P - 1);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_val("rst_busy", o_busy, 0);   check_val("rst_done", o_done, 0);
    check_val("rst_issued", ov_iss, 0); check_val("rst_retired", ov_ret, 0);
    check_val("rst_res", o_res, 0);     check_val("rst_gen", o_gen, 0);
    check_val("rst_dut", o_dut, 0);
    model_reset();
    i_start = 1'b0; i_abort = 1'b0; i_hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  int first_res, last_res, done_k, res_cnt, gen_cnt;

  // one run from start pulse to DONE; hold/abort/gap are per-cycle, directed window plus random rate
  task automatic run(input int cnt, input int hold_lo, input int hold_hi, input int abort_k,
                     input int hold_pct, input int abort_pct, input int gap_sel, input int reset_k);
    int k = 0;
    bit hd, ab, st;
    int gp;
    first_res = -1; last_res = -1; done_k = -1; res_cnt = 0; gen_cnt = 0;
    forever begin
      st = (k == 0) || ($urandom_range(0, 9) == 0);
      hd = (k >= hold_lo && k <= hold_hi) || (k > 0 && $urandom_range(0, 99) < hold_pct);
      ab = (k == abort_k) || (k > 0 && $urandom_range(0, 99) < abort_pct);
      gp = !GAP_EN ? 0 : (gap_sel >= 0 ? gap_sel : int'($urandom_range(0, 3)));
      step(st, ab, hd, (k == 0) ? cnt : int'($urandom_range(0, 20)), gp);
      if (obs_res) begin res_cnt++; last_res = k; if (first_res < 0) first_res = k; end
      if (obs_done) done_k = k;
      if (obs_gen) gen_cnt++;
      if (k == reset_k) begin mid_reset(); return; end
      if (k > 0 && ms == M_IDLE) return;
      k++;
      if (k > 1000) begin check_val("timeout", 1, 0); return; end
    end
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0);
    check_val("reset_busy", o_busy, 0);

    run(4, -1, -1, -1, 0, 0, 0, -1);
    check_val("s1_first_res", first_res, 7);  check_val("s1_last_res", last_res, 10);
    check_val("s1_done_cycle", done_k, 12);   check_val("s1_res_cnt", res_cnt, 4);

    run(0, -1, -1, -1, 0, 0, 0, -1);
    check_val("zero_done_cycle", done_k, 1);  check_val("zero_gen", gen_cnt, 0);

    run(8, 4, 6, -1, 0, 0, 0, -1);
    check_val("hold_first_res", first_res, 10); check_val("hold_res_cnt", res_cnt, 8);

    run(10, -1, -1, 5, 0, 0, 0, -1);
    check_val("abort_res_cnt", res_cnt, 3);

    run(12, -1, -1, -1, 0, 0, 0, 6);
    run(4, -1, -1, -1, 0, 0, 0, -1);
    check_val("post_rst_first_res", first_res, 7);
    check_val("post_rst_done_cycle", done_k, 12);

    if (GAP_EN) begin
      run(3, -1, -1, -1, 0, 0, 2, -1);
      check_val("gap_first_res", first_res, 7); check_val("gap_last_res", last_res, 13);
    end

    for (int r = 0; r < 30; r++)
      run(int'($urandom_range(0, 12)), -1, -1, -1, 15, (r % 2 == 1) ? 4 : 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/float_stim_sequencer.md
# float_stim_sequencer

Run controller for the floating-point operator benches. On a start command it primes the random float generator and issues a programmed number of operands into a pipelined float datapath. It tracks every in-flight operand against the datapath latency and flags each retiring result to the checker. It sits between the bench top level, the generator's clock enable, and the device-under-test's input valid and clock enable.

## Interface
- pExpW, 8, exponent width of issued operands (informational; sizes nothing internally)
- pManW, 23, mantissa width of issued operands (informational)
- pPipeline, 5, datapath latency in cycles, ≥1
- pCntW, 16, width of operand count and statistics counters
- i_Clk  in  1  clock; all registers on rising edge
- i_ARst_L  in  1  asynchronous, active-low reset
- i_Start  in  1  start pulse; sampled only in IDLE
- iv_Count  in  pCntW  number of operands to issue; latched on accepted i_Start
- i_Abort  in  1  stop issuing; drain in-flight operands
- i_Hold  in  1  checker backpressure; freezes generator, datapath and tracking
- o_GenClkEn  out  1  generator clock enable (advance to next operand)
- o_OpValid  out  1  current generator output is a real operand for the datapath
- o_DutClkEn  out  1  datapath clock enable
- o_ResValid  out  1  one-cycle strobe per retiring result
- o_Busy  out  1  state is not IDLE
- o_Done  out  1  one-cycle pulse at run end
- ov_Issued  out  pCntW  operands issued this run
- ov_Retired  out  pCntW  results retired this run

## Operation
- States: IDLE, PRIME, RUN, DRAIN, DONE.
- IDLE:
  - i_Start with iv_Count≠0 → PRIME; latch count; clear ov_Issued, ov_Retired.
  - i_Start with iv_Count=0 → DONE; counters are cleared.
- PRIME:
  - o_GenClkEn=~i_Hold, o_OpValid=0. This loads the first valid operand, because generator registers power up unknown.
  - Goes to RUN when !i_Hold.
  - i_Abort → DRAIN.
- RUN:
  - issue = !i_Hold & !i_Abort & remaining≠0 & gap counter=0.
  - On issue: o_GenClkEn=o_OpValid=1, remaining−1, ov_Issued+1.
  - Last issue → DRAIN.
  - i_Abort → DRAIN, with no issue that cycle. Abort wins over a simultaneous issue.
- DRAIN: waits until the valid tracker is all zero, then goes to DONE. Entered with an empty tracker, it leaves after one cycle.
- DONE: o_Done=1 for exactly one cycle → IDLE.
- Valid tracker:
  - vr_Vld is pPipeline bits.
  - When !i_Hold it shifts with o_OpValid in at bit 0.
  - When i_Hold it holds.
- o_ResValid = vr_Vld[pPipeline−1] & ~i_Hold. Each o_ResValid increments ov_Retired.
- o_DutClkEn = ~i_Hold in PRIME/RUN/DRAIN; 0 in IDLE/DONE.
- i_Start outside IDLE is ignored. i_Abort outside PRIME/RUN is ignored.
- Counters do not wrap within a run, because issues are bounded by iv_Count.

## Timing
- o_GenClkEn, o_OpValid, o_ResValid and o_DutClkEn are combinational from state and inputs. All other outputs are registered.
- Start to first issue: i_Start accepted at edge 0, PRIME during cycle 1, first o_OpValid in cycle 2 (no hold).
- Issue to result: operand issued in cycle t gives o_ResValid in cycle t+pPipeline, plus any i_Hold cycles in between.
- For N back-to-back issues with no hold or gap: o_Done rises pPipeline+2 cycles after the last issue cycle.
- Reset values:
  - state IDLE, vr_Vld=0, remaining=0, gap counter=0.
  - All outputs 0: ov_Issued=ov_Retired=0, o_Busy=0, o_Done=0.
- Reset mid-run: everything returns to IDLE immediately, with no o_Done.

## Configuration
- FLOAT_STIM_SEQ_GAP_EN defined:
  - Adds input iv_Gap [3:0], sampled at each issue.
  - After each issue, the gap counter loads iv_Gap. It decrements on each !i_Hold cycle, and issue is blocked while it is non-zero.
  - o_DutClkEn stays asserted during gaps, so bubbles propagate through the datapath.
  - The gap counter is cleared on entry to DRAIN.
- Not defined: no iv_Gap port; the gap counter is constant 0, and operands issue on every non-held RUN cycle.

## Test plan
- iv_Count=4, pPipeline=5, no hold → PRIME in cycle 1; issues in cycles 2–5; o_ResValid in cycles 7–10; o_Done in cycle 12; ov_Issued=ov_Retired=4.
- iv_Count=0 with i_Start → o_Done on the next cycle; no o_GenClkEn; counters 0.
- iv_Count=8, i_Hold high for cycles 4–6 → no issue, no tracker shift and no o_ResValid during the hold; ov_Retired=8 at o_Done; results arrive 3 cycles later than the no-hold case.
- iv_Count=10, i_Abort in cycle 5 → ov_Issued=3; exactly 3 o_ResValid strobes; then o_Done.
- i_ARst_L low in mid-RUN → all outputs 0 and state IDLE asynchronously; a new start afterwards behaves as in the first scenario.
- With FLOAT_STIM_SEQ_GAP_EN, iv_Gap=2, iv_Count=3 → issues in cycles 2, 5, 8; o_ResValid in cycles 7, 10, 13.
